tero_sequencer: RTL



---
 rtl/tero_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tero_sequencer.sv
// Round-robin measurement sequencer for a bank of TERO cells: clear the shared
// counter, excite one cell, settle, capture the count and hand it to the converter.
module tero_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ON_CYC     = 64,
    parameter int SETTLE_CYC = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [NUM_CH-1:0] CH_MASK,
    input  logic [7:0]        CNT_IN,
    input  logic              STALL,
    output logic [NUM_CH-1:0] TERO_EN,
    output logic              TERO_CLR,
    output logic [CH_W-1:0]   CH,
    output logic [7:0]        DOUT,
    output logic              WE,
    output logic              BUSY,
    output logic [15:0]       TRIALS
);

    localparam int MAX_CYC = (ON_CYC > SETTLE_CYC) ? ON_CYC : SETTLE_CYC;
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        OSC    = 3'd2,
        SETTLE = 3'd3,
        EMIT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [7:0]        dout_q, dout_d;
    logic [15:0]       trials_q, trials_d;
    logic              sel_ok;
    logic [CH_W-1:0]   sel_ch;

    // Lowest enabled index above the last pointer, wrapping; k == NUM_CH lands
    // back on the last cell itself, which covers the single-cell reselect case.
    function automatic logic [CH_W-1:0] pick_next(input logic [CH_W-1:0] last,
                                                  input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic            found;
        int              idx;
        res   = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last) + k) % NUM_CH;
            if (!found && mask[idx]) begin
                res   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign sel_ok = RUN && (|CH_MASK);
    assign sel_ch = pick_next(last_q, CH_MASK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
            phase_q  <= '0;
            dout_q   <= 8'h00;
            trials_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            phase_q  <= phase_d;
            dout_q   <= dout_d;
            trials_q <= trials_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        last_d   = last_q;
        phase_d  = phase_q;
        dout_d   = dout_q;
        trials_d = trials_q;
        unique case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = CLEAR;
                    ch_d    = sel_ch;
                    last_d  = sel_ch;
                end
            end
            CLEAR: begin
                state_d = OSC;
                phase_d = PH_W'(ON_CYC - 1);
            end
            OSC: begin
                if (phase_q == '0) begin
                    state_d = SETTLE;
                    phase_d = PH_W'(SETTLE_CYC - 1);
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            SETTLE: begin
                if (phase_q == '0) begin
                    state_d = EMIT;
                    dout_d  = CNT_IN;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            EMIT: begin
                // Hold the sample until the converter can take it.
                if (!STALL) begin
                    trials_d = trials_q + 16'd1;
                    if (sel_ok) begin
                        state_d = CLEAR;
                        ch_d    = sel_ch;
                        last_d  = sel_ch;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TERO_EN  = (state_q == OSC) ? (NUM_CH'(1) << ch_q) : '0;
    assign TERO_CLR = (state_q == CLEAR);
    assign WE       = (state_q == EMIT) && !STALL;
    assign BUSY     = (state_q != IDLE);
    assign CH       = ch_q;
    assign DOUT     = dout_q;
    assign TRIALS   = trials_q;

endmodule
